// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared BIP opcode values, instruction field layout and fetch state encoding
package bip_pkg;

   localparam int INSTR_WIDTH   = 16;
   localparam int OPCODE_WIDTH  = 5;
   localparam int OPERAND_WIDTH = 11;
   localparam int OPCODE_MSB    = 15;
   localparam int OPCODE_LSB    = 11;
   localparam int OPERAND_MSB   = 10;
   localparam int OPERAND_LSB   = 0;

   localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 5'b00000;
   localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
   localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_EXEC,
      ST_HALT,
      ST_PAUSE
   } fetch_state_t;

endpackage

// File: rtl/bip_fetch_unit_if.sv
// rtl/bip_fetch_unit_if.sv - program memory read port and decoder-facing opcode stream
interface bip_fetch_unit_if
   import bip_pkg::*;
#(
   parameter int PC_WIDTH      = 11,
   parameter int INSTR_WIDTH   = bip_pkg::INSTR_WIDTH,
   parameter int OPCODE_WIDTH  = bip_pkg::OPCODE_WIDTH,
   parameter int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH
);

   logic [PC_WIDTH-1:0]      instr_addr;
   logic                     instr_rd_en;
   logic [INSTR_WIDTH-1:0]   instr_data;
   logic [OPCODE_WIDTH-1:0]  opcode;
   logic [OPERAND_WIDTH-1:0] operand;
   logic                     instr_valid;
   logic                     WrPC;

   modport master (
      output instr_addr, instr_rd_en, opcode, operand, instr_valid,
      input  instr_data, WrPC
   );

   modport slave (
      input  instr_addr, instr_rd_en, opcode, operand, instr_valid,
      output instr_data, WrPC
   );

endinterface

// File: rtl/bip_program_counter.sv
// rtl/bip_program_counter.sv - program counter with restart load, increment enable and natural wrap
module bip_program_counter
   import bip_pkg::*;
#(
   parameter int PC_WIDTH     = 11,
   parameter int RESET_VECTOR = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic                inc_i,
   output logic [PC_WIDTH-1:0] pc_o
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;

   // Increment truncates to PC_WIDTH, so the top address rolls over to zero silently.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = PC_WIDTH'(RESET_VECTOR);
      end else if (inc_i) begin
         pc_d = pc_q + PC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= PC_WIDTH'(RESET_VECTOR);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/bip_fetch_unit.sv
// rtl/bip_fetch_unit.sv - BIP fetch sequencer, 3 cycles per instruction; BIP_FETCH_SINGLE_STEP_EN adds step/PAUSE
module bip_fetch_unit
   import bip_pkg::*;
#(
   parameter int PC_WIDTH     = 11,
   parameter int INSTR_WIDTH  = bip_pkg::INSTR_WIDTH,
   parameter int OPCODE_WIDTH = bip_pkg::OPCODE_WIDTH,
   parameter int RESET_VECTOR = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
`ifdef BIP_FETCH_SINGLE_STEP_EN
   input  logic                step,
`endif
   bip_fetch_unit_if.master    bus,
   output logic [PC_WIDTH-1:0] pc,
   output logic                halted
);

   localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

   fetch_state_t           state_q, state_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   logic                   pc_load;
   logic                   pc_inc;
   logic                   exec;

   bip_program_counter #(
      .PC_WIDTH     (PC_WIDTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .clk    (clk),
      .reset  (reset),
      .load_i (pc_load),
      .inc_i  (pc_inc),
      .pc_o   (pc)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            ir_d    = bus.instr_data;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (bus.WrPC) begin
               pc_inc  = 1'b1;
`ifdef BIP_FETCH_SINGLE_STEP_EN
               state_d = ST_PAUSE;
`else
               state_d = ST_FETCH;
`endif
            end else begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if (start) begin
               pc_load = 1'b1;
               state_d = ST_FETCH;
            end
         end
`ifdef BIP_FETCH_SINGLE_STEP_EN
         ST_PAUSE: if (step) state_d = ST_FETCH;
`endif
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Fields are zeroed outside EXEC so the combinational decoder sees HALT and drives no writes.
   assign exec            = (state_q == ST_EXEC);
   assign bus.instr_addr  = pc;
   assign bus.instr_rd_en = (state_q == ST_FETCH);
   assign bus.instr_valid = exec;
   assign bus.opcode      = exec ? ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] : '0;
   assign bus.operand     = exec ? ir_q[OPERAND_WIDTH-1:0] : '0;
   assign halted          = (state_q == ST_HALT);

endmodule

// File: tb/tb_bip_fetch_unit.sv
// tb/tb_bip_fetch_unit.sv - randomized self-checking bench for bip_fetch_unit against an instruction-level model
module tb_bip_fetch_unit;
   import bip_pkg::*;

   localparam int PCW   = 11;
   localparam int DEPTH = 2048;

   logic           clk = 1'b0;
   logic           reset, start, step;
   logic [PCW-1:0] pc;
   logic           halted;
   logic [15:0]    mem [DEPTH];

   int checks = 0;
   int errors = 0;

   int          exp_pc[$];
   logic [15:0] exp_ins[$];
   bit          exp_halt;
   int          exp_final_pc;

   always #5 clk = ~clk;

   bip_fetch_unit_if bus ();

   bip_fetch_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
`ifdef BIP_FETCH_SINGLE_STEP_EN
      .step   (step),
`endif
      .bus    (bus),
      .pc     (pc),
      .halted (halted)
   );

   always @(posedge clk) begin
      if (bus.instr_rd_en) bus.instr_data <= mem[bus.instr_addr];
      else                 bus.instr_data <= 16'($urandom);
   end

   assign bus.WrPC = (bus.opcode >= 5'd1) && (bus.opcode <= 5'd7);

   task automatic build_model(input int max_execs);
      int p;
      p = 0;
      exp_pc.delete();
      exp_ins.delete();
      exp_halt = 0;
      for (int k = 0; k < max_execs; k++) begin
         exp_pc.push_back(p);
         exp_ins.push_back(mem[p]);
         if (mem[p][15:11] >= 5'd1 && mem[p][15:11] <= 5'd7) begin
            p = (p + 1) % DEPTH;
         end else begin
            exp_halt = 1;
            break;
         end
      end
      exp_final_pc = p;
   endtask

   task automatic run_check(input string tag, input int max_execs);
      int          n;
      logic [15:0] ins;
      build_model(max_execs);
      n = exp_pc.size();
      start = 1'b1;
      for (int k = 0; k < n; k++) begin
         ins = exp_ins[k];
         @(posedge clk); #1;
         start = 1'(($urandom) % 2);
         step  = 1'b0;
         checks++; if (bus.instr_rd_en !== 1'b1) begin errors++; $display("FAIL %s fetch_rd_en k=%0d got %b exp 1", tag, k, bus.instr_rd_en); end
         checks++; if (bus.instr_addr !== PCW'(exp_pc[k])) begin errors++; $display("FAIL %s fetch_addr k=%0d got %0d exp %0d", tag, k, bus.instr_addr, exp_pc[k]); end
         checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL %s fetch_valid k=%0d got %b exp 0", tag, k, bus.instr_valid); end
         @(posedge clk); #1;
         start = 1'(($urandom) % 2);
         checks++; if (bus.instr_rd_en !== 1'b0) begin errors++; $display("FAIL %s load_rd_en k=%0d got %b exp 0", tag, k, bus.instr_rd_en); end
         checks++; if (bus.opcode !== 5'd0) begin errors++; $display("FAIL %s load_opcode k=%0d got %0d exp 0", tag, k, bus.opcode); end
         @(posedge clk); #1;
         start = 1'b0;
         checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL %s exec_valid k=%0d got %b exp 1", tag, k, bus.instr_valid); end
         checks++; if (bus.opcode !== ins[15:11]) begin errors++; $display("FAIL %s exec_opcode k=%0d got %0d exp %0d", tag, k, bus.opcode, ins[15:11]); end
         checks++; if (bus.operand !== ins[10:0]) begin errors++; $display("FAIL %s exec_operand k=%0d got %0d exp %0d", tag, k, bus.operand, ins[10:0]); end
         checks++; if (pc !== PCW'(exp_pc[k])) begin errors++; $display("FAIL %s exec_pc k=%0d got %0d exp %0d", tag, k, pc, exp_pc[k]); end
         checks++; if (halted !== 1'b0) begin errors++; $display("FAIL %s exec_halted k=%0d got %b exp 0", tag, k, halted); end
`ifdef BIP_FETCH_SINGLE_STEP_EN
         if (k < n - 1) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
               start = 1'(($urandom) % 2);
               checks++; if (bus.instr_valid !== 1'b0 || bus.opcode !== 5'd0) begin errors++; $display("FAIL %s pause_out k=%0d got valid=%b op=%0d exp 0/0", tag, k, bus.instr_valid, bus.opcode); end
               checks++; if (pc !== PCW'(exp_pc[k+1])) begin errors++; $display("FAIL %s pause_pc k=%0d got %0d exp %0d", tag, k, pc, exp_pc[k+1]); end
               checks++; if (bus.instr_rd_en !== 1'b0) begin errors++; $display("FAIL %s pause_rd_en k=%0d got %b exp 0", tag, k, bus.instr_rd_en); end
            end
            step = 1'b1;
         end
`endif
      end
      @(posedge clk); #1;
      start = 1'b0;
      step  = 1'b0;
      if (exp_halt) begin
         checks++; if (halted !== 1'b1) begin errors++; $display("FAIL %s halted got %b exp 1", tag, halted); end
         checks++; if (pc !== PCW'(exp_final_pc)) begin errors++; $display("FAIL %s halt_pc got %0d exp %0d", tag, pc, exp_final_pc); end
         checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL %s halt_valid got %b exp 0", tag, bus.instr_valid); end
      end else begin
`ifdef BIP_FETCH_SINGLE_STEP_EN
         checks++; if (bus.instr_valid !== 1'b0 || bus.opcode !== 5'd0) begin errors++; $display("FAIL %s end_pause got valid=%b op=%0d exp 0/0", tag, bus.instr_valid, bus.opcode); end
         checks++; if (pc !== PCW'(exp_final_pc)) begin errors++; $display("FAIL %s end_pause_pc got %0d exp %0d", tag, pc, exp_final_pc); end
`else
         checks++; if (bus.instr_rd_en !== 1'b1) begin errors++; $display("FAIL %s next_fetch_rd_en got %b exp 1", tag, bus.instr_rd_en); end
         checks++; if (bus.instr_addr !== PCW'(exp_final_pc)) begin errors++; $display("FAIL %s next_fetch_addr got %0d exp %0d", tag, bus.instr_addr, exp_final_pc); end
`endif
      end
   endtask

   task automatic fill_random_mem();
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; step = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         checks++; if (pc !== 11'd0) begin errors++; $display("FAIL reset_pc c=%0d got %0d exp 0", c, pc); end
         checks++; if (bus.instr_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en c=%0d got %b exp 0", c, bus.instr_rd_en); end
         checks++; if (bus.opcode !== 5'd0) begin errors++; $display("FAIL reset_opcode c=%0d got %0d exp 0", c, bus.opcode); end
         checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid c=%0d got %b exp 0", c, bus.instr_valid); end
         checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted c=%0d got %b exp 0", c, halted); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_linear();
      fill_random_mem();
      mem[0] = 16'h1805;
      mem[1] = 16'h2803;
      mem[2] = 16'h0000;
      run_check("linear", 16);
      checks++; if (pc !== 11'd2) begin errors++; $display("FAIL linear_final_pc got %0d exp 2", pc); end
   endtask

   task automatic test_undefined();
      fill_random_mem();
      mem[0] = 16'hF800;
      run_check("undef", 16);
      run_check("undef_restart", 16);
   endtask

   task automatic test_random_programs();
      int          len;
      logic [4:0]  term;
      for (int it = 0; it < 6; it++) begin
         fill_random_mem();
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) mem[i] = {5'($urandom_range(1, 7)), 11'($urandom)};
         term = ($urandom % 2) ? 5'd0 : 5'($urandom_range(8, 31));
         mem[len] = {term, 11'($urandom)};
         run_check($sformatf("rand%0d", it), len + 1);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < DEPTH; i++) mem[i] = {OP_ADDI, 11'($urandom)};
      run_check("wrap", DEPTH);
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) mem[i] = {OP_ADDI, 11'($urandom)};
      run_check("mid_prep", 3);
`ifdef BIP_FETCH_SINGLE_STEP_EN
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
`endif
      @(posedge clk); #1;
      checks++; if (bus.instr_rd_en !== 1'b0 || pc !== 11'd3) begin errors++; $display("FAIL mid_load got rd_en=%b pc=%0d exp 0/3", bus.instr_rd_en, pc); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (pc !== 11'd0) begin errors++; $display("FAIL mid_reset_pc got %0d exp 0", pc); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", bus.instr_valid); end
      checks++; if (bus.instr_rd_en !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl got rd_en=%b halted=%b exp 0/0", bus.instr_rd_en, halted); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++; if (bus.instr_valid !== 1'b0 || bus.opcode !== 5'd0 || bus.operand !== 11'd0) begin errors++; $display("FAIL mid_idle c=%0d got valid=%b op=%0d opnd=%0d exp 0/0/0", c, bus.instr_valid, bus.opcode, bus.operand); end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      step  = 1'b0;
      test_reset();
      test_linear();
      test_undefined();
      test_random_programs();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
